// File: rtl/cr_cddip_sa_dump_pkg.sv
// Shared types and widths for the statistics-aggregator dump engine.
// Latency: none (types only). Backpressure: n/a.
package cr_cddip_saPKG;

    localparam int SA_DUMP_TAG_WIDTH  = 8;
    localparam int SA_DUMP_IDX_WIDTH  = 6;
    localparam int SA_DUMP_CNT_WIDTH  = 50;
    localparam int SA_DUMP_BANK_DEPTH = 64;

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        WAIT,
        SEND,
        CLR
    } sa_dump_state_e;

    typedef struct packed {
        logic [SA_DUMP_TAG_WIDTH-1:0] tag;
        logic [SA_DUMP_IDX_WIDTH-1:0] index;
        logic [SA_DUMP_CNT_WIDTH-1:0] count;
    } sa_dump_word_t;

endpackage

// File: rtl/cr_cddip_sa_dump_sel.sv
// Snapshot bank selector: picks one 50-bit counter by index and flags zero.
// Latency: combinational. Backpressure: n/a.
module cr_sa_dump_sel
    import cr_cddip_saPKG::*;
#(
    parameter bit ZERO_EN = 1'b0
) (
    input  logic [SA_DUMP_BANK_DEPTH-1:0][SA_DUMP_CNT_WIDTH-1:0] snapshot,
    input  logic [SA_DUMP_IDX_WIDTH-1:0]                         idx,
    output logic [SA_DUMP_CNT_WIDTH-1:0]                         count,
    output logic                                                 zero
);

    assign count = snapshot[idx];
    // Zero flag is forced low when skipping is not built in.
    assign zero  = ZERO_EN && (count == '0);

endmodule

// File: rtl/cr_cddip_sa_dump.sv
// Snaps the aggregator bank, streams every entry as {tag,index,count}; CR_CDDIP_SA_DUMP_SKIP_ZERO_EN drops zero entries.
// Latency: first word SNAP_WAIT+2 cycles after dump_req, then one word per accepted cycle.
// Backpressure: output register holds while dump_ready is low; the scan index stalls with it.
module cr_cddip_sa_dump
    import cr_cddip_saPKG::*;
#(
    parameter int NUM_CNT   = 64,
    parameter int SNAP_WAIT = 4
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 dump_req,
    input  logic                                                 dump_clear,
    input  logic [SA_DUMP_TAG_WIDTH-1:0]                         dump_tag,
    input  logic [SA_DUMP_BANK_DEPTH-1:0][SA_DUMP_CNT_WIDTH-1:0] sa_snapshot,
    output logic                                                 sa_snap_req,
    output logic                                                 sa_clear_req,
    output logic                                                 dump_busy,
    output logic                                                 dump_valid,
    input  logic                                                 dump_ready,
    output logic [63:0]                                          dump_data,
    output logic                                                 dump_last
);

    localparam int WCW = $clog2(SNAP_WAIT + 1);
    localparam logic [SA_DUMP_IDX_WIDTH-1:0] LAST_IDX = SA_DUMP_IDX_WIDTH'(NUM_CNT - 1);
`ifdef CR_CDDIP_SA_DUMP_SKIP_ZERO_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    sa_dump_state_e                state;
    logic [SA_DUMP_IDX_WIDTH-1:0]  idx;
    logic [WCW-1:0]                wcnt;
    logic [SA_DUMP_TAG_WIDTH-1:0]  tag_q;
    logic                          clr_q;
    sa_dump_word_t                 word_q;
    logic [SA_DUMP_CNT_WIDTH-1:0]  sel_count;
    logic                          sel_zero;
    logic                          at_last;
    logic                          skip_ent;
    logic                          hs;
    logic                          wait_done;
    logic                          scan;

    cr_sa_dump_sel #(
        .ZERO_EN (SKIP_EN)
    ) u_sel (
        .snapshot (sa_snapshot),
        .idx      (idx),
        .count    (sel_count),
        .zero     (sel_zero)
    );

    assign at_last   = (idx == LAST_IDX);
    assign skip_ent  = sel_zero && !at_last;
    assign hs        = dump_valid && dump_ready;
    assign wait_done = (wcnt == WCW'(SNAP_WAIT - 1));
    // A scan slot opens when the register is empty or drains, until the last word is in it.
    assign scan      = ((state == WAIT) && wait_done) ||
                       ((state == SEND) && (!dump_valid || (hs && !dump_last)));
    assign dump_data = word_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            wcnt         <= '0;
            tag_q        <= '0;
            clr_q        <= 1'b0;
            word_q       <= '0;
            sa_snap_req  <= 1'b0;
            sa_clear_req <= 1'b0;
            dump_busy    <= 1'b0;
            dump_valid   <= 1'b0;
            dump_last    <= 1'b0;
        end else begin
            sa_snap_req  <= 1'b0;
            sa_clear_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (dump_req) begin
                        state       <= SNAP;
                        sa_snap_req <= 1'b1;
                        dump_busy   <= 1'b1;
                        tag_q       <= dump_tag;
                        clr_q       <= dump_clear;
                        idx         <= '0;
                    end
                end
                SNAP: begin
                    state <= WAIT;
                    wcnt  <= '0;
                end
                WAIT: begin
                    if (wait_done) begin
                        state <= SEND;
                    end else begin
                        wcnt <= wcnt + WCW'(1);
                    end
                end
                SEND: begin
                    if (hs && dump_last) begin
                        dump_valid <= 1'b0;
                        dump_last  <= 1'b0;
                        if (clr_q) begin
                            state        <= CLR;
                            sa_clear_req <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            dump_busy <= 1'b0;
                        end
                    end
                end
                CLR: begin
                    state     <= IDLE;
                    dump_busy <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    dump_busy <= 1'b0;
                end
            endcase

            if (scan) begin
                if (skip_ent) begin
                    dump_valid <= 1'b0;
                end else begin
                    dump_valid   <= 1'b1;
                    dump_last    <= at_last;
                    word_q.tag   <= tag_q;
                    word_q.index <= idx;
                    word_q.count <= sel_count;
                end
                if (!at_last) begin
                    idx <= idx + SA_DUMP_IDX_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cr_cddip_sa_dump.sv
// Randomized bench for cr_cddip_sa_dump against a queue-based stream model.
module tb_cr_cddip_sa_dump;

    localparam int NUM_CNT   = 64;
    localparam int SNAP_WAIT = 4;
`ifdef CR_CDDIP_SA_DUMP_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              dump_req;
    logic              dump_clear;
    logic [7:0]        dump_tag;
    logic [63:0][49:0] sa_snapshot;
    logic              sa_snap_req;
    logic              sa_clear_req;
    logic              dump_busy;
    logic              dump_valid;
    logic              dump_ready;
    logic [63:0]       dump_data;
    logic              dump_last;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q[$];

    cr_cddip_sa_dump #(
        .NUM_CNT   (NUM_CNT),
        .SNAP_WAIT (SNAP_WAIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dump_req     (dump_req),
        .dump_clear   (dump_clear),
        .dump_tag     (dump_tag),
        .sa_snapshot  (sa_snapshot),
        .sa_snap_req  (sa_snap_req),
        .sa_clear_req (sa_clear_req),
        .dump_busy    (dump_busy),
        .dump_valid   (dump_valid),
        .dump_ready   (dump_ready),
        .dump_data    (dump_data),
        .dump_last    (dump_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Expected stream: every entry in index order, zeros dropped (except the final one) when skipping.
    task automatic build_model(input logic [7:0] tag);
        exp_q.delete();
        for (int i = 0; i < NUM_CNT; i++) begin
            if (!(SKIP && sa_snapshot[i] == 50'd0 && i != NUM_CNT - 1))
                exp_q.push_back({tag, 6'(i), sa_snapshot[i]});
        end
    endtask

    task automatic fill_random(input int zero_odds);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) begin
            r = {$urandom(), $urandom()};
            sa_snapshot[i] = ($urandom_range(0, 99) < zero_odds) ? 50'd0 : r[49:0];
        end
    endtask

    // mode 0: ready high; 1: random ready + 20-cycle stall on index 5;
    // 2: extra dump_req during WAIT and SEND; 3: reset once index >= 30 is presented.
    task automatic run_dump(input logic clr, input logic [7:0] tag, input int mode);
        int          c;
        int          snaps;
        int          clears;
        int          stall;
        bit          done;
        bit          aborted;
        logic        pv;
        logic        pr;
        logic        pl;
        logic [63:0] pd;
        logic [63:0] e;

        dump_tag   = tag;
        dump_clear = clr;
        dump_req   = 1'b1;
        dump_ready = (mode != 1);
        step;
        dump_req   = 1'b0;
        dump_clear = $urandom_range(0, 1);
        dump_tag   = 8'($urandom());
        chk("snap_pulse", sa_snap_req, 1);
        chk("busy_rise", dump_busy, 1);
        chk("no_valid_in_snap", dump_valid, 0);
        build_model(tag);

        c = 1; snaps = 0; clears = 0; stall = 0;
        done = 1'b0; aborted = 1'b0;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        while (!done && !aborted && c < 4000) begin
            step;
            c++;
            if (sa_snap_req)  snaps++;
            if (sa_clear_req) clears++;
            if (pv && !pr) begin
                chk("hold_vld", dump_valid, 1);
                chk("hold_dat", dump_data, pd);
                chk("hold_last", dump_last, pl);
            end
            dump_req = (mode == 2) && (c == 3 || c == 2 + SNAP_WAIT + 10);
            if (mode == 1) begin
                if (dump_valid && dump_data[55:50] == 6'd5 && stall < 20) begin
                    dump_ready = 1'b0;
                    stall++;
                end else begin
                    dump_ready = 1'($urandom_range(0, 1));
                end
            end else begin
                dump_ready = 1'b1;
            end
            if (mode == 3 && dump_valid && dump_data[55:50] >= 6'd30) begin
                rst = 1'b1;
                step;
                rst = 1'b0;
                chk("rst_valid", dump_valid, 0);
                chk("rst_busy", dump_busy, 0);
                chk("rst_last", dump_last, 0);
                aborted = 1'b1;
            end else if (dump_valid && dump_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", dump_valid, 0);
                    done = 1'b1;
                end else begin
                    e = exp_q.pop_front();
                    chk("word", dump_data, e);
                    chk("last", dump_last, exp_q.size() == 0);
                    if (mode == 0 || mode == 2)
                        chk("word_time", c, 2 + SNAP_WAIT + int'(e[55:50]));
                    if (exp_q.size() == 0) done = 1'b1;
                end
            end
            pv = dump_valid; pr = dump_ready; pd = dump_data; pl = dump_last;
        end
        dump_req   = 1'b0;
        dump_ready = 1'b1;
        if (aborted) return;

        chk("stream_done", done, 1);
        chk("extra_snap", snaps, 0);
        chk("clear_early", clears, 0);
        if (mode == 1) chk("stall_len", stall, 20);
        step;
        chk("clear_pulse", sa_clear_req, clr);
        chk("valid_drop", dump_valid, 0);
        chk("snap_after", sa_snap_req, 0);
        if (clr) begin
            chk("busy_in_clr", dump_busy, 1);
            step;
            chk("clear_single", sa_clear_req, 0);
        end
        chk("busy_fall", dump_busy, 0);
    endtask

    initial begin
        rst         = 1'b1;
        dump_req    = 1'b0;
        dump_clear  = 1'b0;
        dump_tag    = 8'h00;
        dump_ready  = 1'b1;
        sa_snapshot = '0;
        repeat (3) step;
        chk("rst_snap", sa_snap_req, 0);
        chk("rst_clear", sa_clear_req, 0);
        chk("rst_busy0", dump_busy, 0);
        chk("rst_valid0", dump_valid, 0);
        chk("rst_last0", dump_last, 0);
        chk("rst_data", dump_data, 0);
        rst = 1'b0;
        step;

        for (int i = 0; i < 64; i++) sa_snapshot[i] = 50'(i * 3);
        run_dump(1'b0, 8'hA5, 0);

        fill_random(20);
        sa_snapshot[5] = 50'h2_5555_AAAA_1234;
        run_dump(1'b0, 8'($urandom()), 1);

        fill_random(10);
        run_dump(1'b1, 8'h3C, 0);
        run_dump(1'b1, 8'hC3, 1);

        fill_random(30);
        run_dump(1'b0, 8'h5A, 2);

        fill_random(0);
        run_dump(1'b1, 8'h11, 3);
        step;
        run_dump(1'b0, 8'h22, 0);

        sa_snapshot     = '0;
        sa_snapshot[3]  = 50'h123;
        sa_snapshot[40] = 50'h3_FFFF_FFFF_FFFF;
        run_dump(1'b0, 8'h77, 0);

        for (int k = 0; k < 4; k++) begin
            fill_random(40);
            run_dump(1'($urandom_range(0, 1)), 8'($urandom()), int'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
